// File: rtl/hash_msg_padder.sv
// Merkle-Damgard message padder: packs a byte stream into hash input blocks and appends 0x80,
// zero padding and the message bit length (big- or little-endian) for MD5 / SHA-1 / SHA-2 cores.
`timescale 1ns/1ps

module hash_msg_padder #(
    parameter int BLOCK_BITS        = 512,
    parameter int LEN_BITS          = 64,
    parameter bit LEN_LITTLE_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_BITS-1:0] out_block,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int BLOCK_BYTES = BLOCK_BITS / 8;
    localparam int LEN_BYTES   = LEN_BITS / 8;
    localparam int LEN_POS     = BLOCK_BYTES - LEN_BYTES;
    localparam int IDX_W       = $clog2(BLOCK_BYTES + 1);
    localparam int CNT_W       = LEN_BITS - 3;

    typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_EMIT} state_e;

    state_e                state_q, state_d;
    state_e                ret_q, ret_d;
    logic [BLOCK_BITS-1:0] blk_q, blk_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      bcnt_q, bcnt_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;

    logic [LEN_BITS-1:0]   bit_len;
    logic [IDX_W-1:0]      idx_inc;

    assign bit_len = {bcnt_q, 3'b000};
    assign idx_inc = idx_q + 1'b1;

    // Byte i of the block lives at the MSB end, so byte 0 is the first byte the core hashes.
    function automatic logic [BLOCK_BITS-1:0] put_byte(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [IDX_W-1:0]      pos,
                                                       input logic [7:0]            val);
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (pos == IDX_W'(i)) blk[BLOCK_BITS-1-8*i -: 8] = val;
        end
        return blk;
    endfunction

    // NOTE: every variable assigned here gets a default first, otherwise latches are inferred.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        first_d = first_q;
        last_d  = last_q;

        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    if (in_last && in_empty) begin
                        state_d = S_PAD;
                    end else begin
                        blk_d  = put_byte(blk_q, idx_q, in_data);
                        idx_d  = idx_inc;
                        bcnt_d = bcnt_q + 1'b1;
                        if (idx_inc == IDX_W'(BLOCK_BYTES)) begin
                            state_d = S_EMIT;
                            last_d  = 1'b0;
                            ret_d   = in_last ? S_PAD : S_FILL;
                        end else if (in_last) begin
                            state_d = S_PAD;
                        end
                    end
                end
            end

            S_PAD: begin
                blk_d = put_byte(blk_q, idx_q, 8'h80);
                idx_d = idx_inc;
                if (idx_inc <= IDX_W'(LEN_POS)) begin
                    state_d = S_LEN;
                end else begin
                    // No room left for the length field: flush and carry it in an extra block.
                    state_d = S_EMIT;
                    last_d  = 1'b0;
                    ret_d   = S_LEN;
                end
            end

            S_LEN: begin
                for (int j = 0; j < LEN_BYTES; j++) begin
                    if (LEN_LITTLE_ENDIAN)
                        blk_d[BLOCK_BITS-1-8*(LEN_POS+j) -: 8] = bit_len[8*j +: 8];
                    else
                        blk_d[BLOCK_BITS-1-8*(LEN_POS+j) -: 8] = bit_len[LEN_BITS-1-8*j -: 8];
                end
                state_d = S_EMIT;
                last_d  = 1'b1;
                ret_d   = S_FILL;
            end

            S_EMIT: begin
                if (out_ready) begin
                    blk_d   = '0;
                    idx_d   = '0;
                    first_d = 1'b0;
                    if (last_q) begin
                        bcnt_d  = '0;
                        first_d = 1'b1;
                    end
                    state_d = ret_q;
                end
            end

            default: state_d = S_FILL;
        endcase
    end

    // NOTE: the block buffer is reset on purpose; an all-zero buffer is what provides the zero padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            ret_q   <= S_FILL;
            blk_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (state_q == S_EMIT);
    assign out_block = blk_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_hash_msg_padder.sv
// Bench for hash_msg_padder: SHA-256, MD5 and SHA-512 configurations compared against a
// byte-queue padding model, plus directed latency, backpressure and reset scenarios.
`timescale 1ns/1ps

module tb_hash_msg_padder;

    typedef logic [7:0] byte_q [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, in_empty, out_ready;
    logic [7:0]  in_data;
    int          sel;

    logic [2:0]    iv, ordy, irdy, ov, ofst, olst;
    logic [511:0]  blk0, blk1;
    logic [1023:0] blk2;

    logic          in_ready_m, out_valid_m, out_first_m, out_last_m;
    logic [1023:0] out_block_m;

    int checks   = 0;
    int failures = 0;

    logic [1023:0] exp_blk[$];
    bit            exp_first[$];
    bit            exp_last[$];

    always #5 clk = ~clk;

    assign iv   = in_valid  ? (3'b001 << sel) : 3'b000;
    assign ordy = out_ready ? (3'b001 << sel) : 3'b000;

    hash_msg_padder #(.BLOCK_BITS(512), .LEN_BITS(64), .LEN_LITTLE_ENDIAN(1'b0)) u_sha256 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_block(blk0), .out_first(ofst[0]), .out_last(olst[0]));

    hash_msg_padder #(.BLOCK_BITS(512), .LEN_BITS(64), .LEN_LITTLE_ENDIAN(1'b1)) u_md5 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_block(blk1), .out_first(ofst[1]), .out_last(olst[1]));

    hash_msg_padder #(.BLOCK_BITS(1024), .LEN_BITS(128), .LEN_LITTLE_ENDIAN(1'b0)) u_sha512 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_block(blk2), .out_first(ofst[2]), .out_last(olst[2]));

    // 512-bit blocks are left-aligned so byte i is always at [1023-8*i -: 8].
    always_comb begin
        in_ready_m  = irdy[0];
        out_valid_m = ov[0];
        out_first_m = ofst[0];
        out_last_m  = olst[0];
        out_block_m = {blk0, 512'b0};
        case (sel)
            1: begin
                in_ready_m = irdy[1]; out_valid_m = ov[1]; out_first_m = ofst[1];
                out_last_m = olst[1]; out_block_m = {blk1, 512'b0};
            end
            2: begin
                in_ready_m = irdy[2]; out_valid_m = ov[2]; out_first_m = ofst[2];
                out_last_m = olst[2]; out_block_m = blk2;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_blk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
        int fb;
        checks++;
        assert (obs === expv) else begin
            failures++;
            fb = -1;
            for (int i = 127; i >= 0; i--)
                if (obs[1023-8*i -: 8] !== expv[1023-8*i -: 8]) fb = i;
            $error("FAIL %s first bad byte %0d observed=%02h expected=%02h", tag, fb,
                   obs[1023-8*fb -: 8], expv[1023-8*fb -: 8]);
        end
    endtask

    // Reference padding: message, 0x80, zeros up to the length slot, length, then cut into blocks.
    task automatic build(input byte_q msg, input int bb, input int lb, input bit le);
        byte_q         p;
        logic [127:0]  len_bits;
        logic [1023:0] b;
        int            nb;
        exp_blk.delete();
        exp_first.delete();
        exp_last.delete();
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % bb) != bb - lb) p.push_back(8'h00);
        len_bits = 128'(msg.size()) << 3;
        for (int j = 0; j < lb; j++)
            p.push_back(le ? len_bits[8*j +: 8] : len_bits[8*(lb-1-j) +: 8]);
        nb = p.size() / bb;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int i = 0; i < bb; i++) b[1023-8*i -: 8] = p[k*bb+i];
            exp_blk.push_back(b);
            exp_first.push_back(k == 0);
            exp_last.push_back(k == nb - 1);
        end
    endtask

    function automatic byte_q zeros(input int n);
        byte_q q;
        for (int i = 0; i < n; i++) q.push_back(8'h00);
        return q;
    endfunction

    function automatic byte_q rand_msg(input int n);
        byte_q q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic empty);
        in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    endtask

    task automatic send_seq(input byte_q msg, input bit empty_tail);
        int n = msg.size();
        for (int i = 0; i < n; i++) drive_byte(msg[i], !empty_tail && (i == n - 1), 1'b0);
        if (empty_tail || n == 0) drive_byte(8'h00, 1'b1, 1'b1);
    endtask

    // Called one sample point after the triggering edge; n counts edges from that edge.
    task automatic wait_valid(input int max_n, output int n);
        n = 1;
        while (!out_valid_m && n < max_n) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_block(input string tag, input int k);
        check_blk({tag, "_block"}, out_block_m, exp_blk[k]);
        check({tag, "_first"}, out_first_m, exp_first[k]);
        check({tag, "_last"}, out_last_m, exp_last[k]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready_m, 1);
        check({tag, "_out_valid"}, out_valid_m, 0);
        check_blk({tag, "_out_block"}, out_block_m, '0);
        check({tag, "_out_first"}, out_first_m, 1);
        check({tag, "_out_last"}, out_last_m, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Random valid gaps, random out_ready stalls, random in_empty on non-final bytes.
    task automatic run_msg(input string tag, input int k, input byte_q msg, input bit empty_tail);
        int            bb    = (k == 2) ? 128 : 64;
        int            lb    = (k == 2) ? 16 : 8;
        int            nbyte = msg.size();
        bit            term  = empty_tail || (nbyte == 0);
        int            total = nbyte + (term ? 1 : 0);
        int            pos = 0, got = 0, cyc = 0, nblk;
        bit            stalled = 0, hs_in;
        logic [1023:0] prev = '0;
        sel = k;
        build(msg, bb, lb, k == 1);
        nblk = exp_blk.size();
        while (got < nblk && cyc < 5000) begin
            if (pos < total && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                if (pos < nbyte) begin
                    in_data  = msg[pos];
                    in_last  = !term && (pos == nbyte - 1);
                    in_empty = !in_last && ($urandom_range(0, 3) == 0);
                end else begin
                    in_data  = 8'($urandom);
                    in_last  = 1'b1;
                    in_empty = 1'b1;
                end
            end else begin
                in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'b0; in_empty = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid_m) begin
                check({tag, "_in_ready_low"}, in_ready_m, 0);
                if (stalled) check_blk({tag, "_stall_hold"}, out_block_m, prev);
                if (out_ready) begin
                    expect_block(tag, got);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev    = out_block_m;
                end
            end
            hs_in = in_valid && in_ready_m;
            @(posedge clk); #1;
            cyc++;
            if (hs_in) pos++;
        end
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; out_ready = 1'b0;
        check({tag, "_blocks"}, got, nblk);
        check({tag, "_consumed"}, pos, total);
    endtask

    initial begin
        byte_q abc;
        int    n;
        abc = '{8'h61, 8'h62, 8'h63};
        sel = 0; rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            check_reset_state("reset");
        end
        sel = 0;

        // "abc", SHA-256: latency, contents, then 10 cycles of backpressure.
        send_seq(abc, 1'b0);
        wait_valid(50, n);
        check("abc_latency", n, 3);
        build(abc, 64, 8, 1'b0);
        expect_block("abc", 0);
        check("abc_head", out_block_m[1023 -: 32], 32'h61626380);
        check("abc_len", out_block_m[1023-8*56 -: 64], 64'h18);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid_m, 1);
            check("bp_in_ready", in_ready_m, 0);
            check_blk("bp_block", out_block_m, exp_blk[0]);
        end
        handshake();
        check("abc_done_valid", out_valid_m, 0);
        check("abc_done_ready", in_ready_m, 1);

        // Empty message.
        send_seq(zeros(0), 1'b0);
        wait_valid(50, n);
        check("empty_latency", n, 3);
        build(zeros(0), 64, 8, 1'b0);
        expect_block("empty", 0);
        check("empty_head", out_block_m[1023 -: 8], 8'h80);
        handshake();

        // 55 bytes fit in one block; 56 bytes spill the length into a second block.
        send_seq(zeros(55), 1'b0);
        wait_valid(50, n);
        check("z55_latency", n, 3);
        build(zeros(55), 64, 8, 1'b0);
        expect_block("z55", 0);
        check("z55_len", out_block_m[1023-8*56 -: 64], 64'h1B8);
        handshake();

        send_seq(zeros(56), 1'b0);
        wait_valid(50, n);
        check("z56_b1_latency", n, 2);
        build(zeros(56), 64, 8, 1'b0);
        expect_block("z56_b1", 0);
        handshake();
        wait_valid(50, n);
        check("z56_b2_latency", n, 2);
        expect_block("z56_b2", 1);
        check("z56_len", out_block_m[1023-8*56 -: 64], 64'h1C0);
        handshake();

        // Exact fill, SHA-256 then MD5.
        send_seq(zeros(64), 1'b0);
        wait_valid(50, n);
        check("z64_b1_latency", n, 1);
        build(zeros(64), 64, 8, 1'b0);
        expect_block("z64_b1", 0);
        handshake();
        wait_valid(50, n);
        check("z64_b2_latency", n, 3);
        expect_block("z64_b2", 1);
        check("z64_len", out_block_m[1023-8*56 -: 64], 64'h200);
        handshake();

        sel = 1;
        send_seq(zeros(64), 1'b0);
        wait_valid(50, n);
        build(zeros(64), 64, 8, 1'b1);
        expect_block("md5_b1", 0);
        handshake();
        wait_valid(50, n);
        expect_block("md5_b2", 1);
        check("md5_len", out_block_m[1023-8*56 -: 64], 64'h0002000000000000);
        handshake();

        // SHA-512 "abc".
        sel = 2;
        send_seq(abc, 1'b0);
        wait_valid(50, n);
        check("s512_latency", n, 3);
        build(abc, 128, 16, 1'b0);
        expect_block("s512_abc", 0);
        check("s512_pad", out_block_m[1023-8*3 -: 8], 8'h80);
        check("s512_len_hi", out_block_m[1023-8*112 -: 120], 120'h0);
        check("s512_len_lo", out_block_m[1023-8*127 -: 8], 8'h18);
        handshake();

        // Randomized messages around block and length-slot boundaries.
        foreach (abc[i]) ;
        run_msg("r256_55", 0, rand_msg(55), 1'b0);
        run_msg("r256_56", 0, rand_msg(56), 1'b1);
        run_msg("r256_63", 0, rand_msg(63), 1'b0);
        run_msg("r256_64", 0, rand_msg(64), 1'b1);
        run_msg("r256_65", 0, rand_msg(65), 1'b0);
        run_msg("r256_120", 0, rand_msg(120), 1'b0);
        run_msg("r256_empty", 0, rand_msg(0), 1'b1);
        for (int r = 0; r < 3; r++) begin
            run_msg("r256_rand", 0, rand_msg($urandom_range(0, 200)), 1'($urandom_range(0, 1)));
            run_msg("rmd5_rand", 1, rand_msg($urandom_range(0, 200)), 1'($urandom_range(0, 1)));
        end
        run_msg("rmd5_56", 1, rand_msg(56), 1'b0);
        run_msg("r512_111", 2, rand_msg(111), 1'b0);
        run_msg("r512_112", 2, rand_msg(112), 1'b1);
        run_msg("r512_128", 2, rand_msg(128), 1'b0);
        run_msg("r512_rand", 2, rand_msg($urandom_range(0, 300)), 1'b0);

        // Reset mid-message, then mid-EMIT.
        sel = 0;
        send_seq(rand_msg(5), 1'b1);
        pulse_reset();
        check_reset_state("rst_mid_msg");
        run_msg("after_rst1", 0, abc, 1'b0);

        sel = 0;
        send_seq(abc, 1'b0);
        wait_valid(50, n);
        check("pre_rst_valid", out_valid_m, 1);
        pulse_reset();
        check_reset_state("rst_mid_emit");
        run_msg("after_rst2", 0, abc, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
